// File: rtl/hp_display_seq.sv
// Frame sequencer for the HP serial dot-matrix display port: replays a CPU-filled
// dot-column buffer (or a single control word) through the port's register interface.
module hp_display_seq #(
    parameter int N_BYTES = 20,
    parameter int TIMEOUT = 1023
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        WE,
    input  logic [3:0]  A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        D_WE,
    output logic [3:0]  D_A,
    output logic [31:0] D_WD,
    input  logic [31:0] D_RD
);
    localparam int PW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int IW = $clog2(N_BYTES + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [PW-1:0] PTR_LAST  = PW'(N_BYTES - 1);
    localparam logic [PW:0]   NB_EXT    = (PW+1)'(N_BYTES);
    localparam logic [IW-1:0] LEN_FRAME = IW'(N_BYTES);
    localparam logic [IW-1:0] LEN_ONE   = IW'(1);
    localparam logic [TW-1:0] CNT_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] CNT_MAX   = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, SEL, WR, GUARD, WAIT, NEXT, DESEL, FIN
    } state_t;

    state_t        state_reg, state_next;
    logic          rs_reg, rs_next;
    logic [IW-1:0] len_reg, len_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [TW-1:0] cnt_reg, cnt_next;
    logic          done_reg, done_next;
    logic          err_reg, err_next;

    logic [PW-1:0] ptr_reg;
    logic [2:0]    cfg_reg;
    logic [7:0]    cword_reg;
    logic [7:0]    buf_mem [N_BYTES];
    logic [7:0]    rd_byte;

    logic cmd_wr, start_frame, start_ctrl, abort, clr_status, abort_hit, busy;
    logic unused_bits;

    assign cmd_wr      = WE && (A == 4'd0);
    assign start_frame = cmd_wr && WD[0];
    assign start_ctrl  = cmd_wr && WD[1];
    assign abort       = cmd_wr && WD[2];
    assign clr_status  = cmd_wr && WD[3];
    assign busy        = (state_reg != IDLE);
    assign abort_hit   = abort && (state_reg inside {WR, GUARD, WAIT, NEXT});
    assign rd_byte     = buf_mem[idx_reg[PW-1:0]];
    assign unused_bits = ^{WD[31:8], D_RD[31:1]};

    // CPU-side registers stay writable while a frame is running.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ptr_reg   <= '0;
            cfg_reg   <= '0;
            cword_reg <= '0;
        end else if (WE) begin
            case (A)
                4'd1: cfg_reg   <= WD[2:0];
                4'd2: ptr_reg   <= WD[PW-1:0];
                4'd3: ptr_reg   <= (ptr_reg == PTR_LAST) ? '0 : ptr_reg + 1'b1;
                4'd4: cword_reg <= WD[7:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (WE && (A == 4'd3) && ({1'b0, ptr_reg} < NB_EXT))
            buf_mem[ptr_reg] <= WD[7:0];
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg <= IDLE;
            rs_reg    <= 1'b0;
            len_reg   <= '0;
            idx_reg   <= '0;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            rs_reg    <= rs_next;
            len_reg   <= len_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rs_next    = rs_reg;
        len_next   = len_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        done_next  = done_reg && !clr_status;
        err_next   = err_reg && !clr_status;
        case (state_reg)
            IDLE: begin
                if (start_frame) begin
                    rs_next    = 1'b0;
                    len_next   = LEN_FRAME;
                    idx_next   = '0;
                    state_next = SEL;
                end else if (start_ctrl) begin
                    rs_next    = 1'b1;
                    len_next   = LEN_ONE;
                    idx_next   = '0;
                    state_next = SEL;
                end
            end
            SEL:   state_next = WR;
            WR:    state_next = GUARD;
            GUARD: begin
                cnt_next   = '0;
                state_next = WAIT;
            end
            // The counter holds completed busy cycles; the TIMEOUT-th busy WAIT cycle gives up.
            WAIT: begin
                if (!D_RD[0]) begin
                    state_next = NEXT;
                end else if (cnt_reg >= CNT_LAST) begin
                    err_next   = 1'b1;
                    state_next = DESEL;
                end else begin
                    cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
                end
            end
            NEXT: begin
                idx_next   = idx_reg + 1'b1;
                state_next = (idx_reg == len_reg - 1'b1) ? DESEL : WR;
            end
            DESEL: state_next = FIN;
            FIN: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (abort_hit) begin
            state_next = DESEL;
            err_next   = err_reg && !clr_status;
        end
    end

    always_comb begin
        D_WE = 1'b0;
        D_A  = 4'd0;
        D_WD = 32'd0;
        case (state_reg)
            SEL: begin
                D_WE = 1'b1;
                D_A  = 4'd1;
                D_WD = {27'd0, cfg_reg, rs_reg, 1'b1};
            end
            WR: begin
                D_WE = 1'b1;
                D_WD = {24'd0, rs_reg ? cword_reg : rd_byte};
            end
            // CE low-to-high here latches the shifted data into the display.
            DESEL: begin
                D_WE = 1'b1;
                D_A  = 4'd1;
                D_WD = {27'd0, cfg_reg, rs_reg, 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        RD = 32'd0;
        case (A)
            4'd0: RD = {29'd0, err_reg, done_reg, busy};
            4'd1: RD = {29'd0, cfg_reg};
            4'd2: RD = 32'(ptr_reg);
            4'd4: RD = {24'd0, cword_reg};
            default: RD = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_hp_display_seq.sv
// Scoreboard bench for hp_display_seq: expected port writes are queued by the stimulus
// and popped by a monitor whenever the sequencer strobes the display port.
module tb_hp_display_seq;
    localparam int TMO = 100;
    localparam int NB  = 20;

    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] wd;
    } dwr_t;

    logic        CLK;
    logic        RESET_N;
    logic        WE;
    logic [3:0]  A;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        D_WE;
    logic [3:0]  D_A;
    logic [31:0] D_WD;
    logic [31:0] D_RD;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int desel_cnt = 0;
    int sel_cyc = 0;
    int desel_cyc = 0;
    int wr_cyc = 0;
    int last_wr_cyc = 0;
    int idle_bad = 0;
    int busy_cnt = 0;
    int hold = 2;
    bit stuck = 0;
    dwr_t exp_q[$];
    dwr_t mon_e;

    hp_display_seq #(.N_BYTES(NB), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .WE(WE), .A(A), .WD(WD), .RD(RD),
        .D_WE(D_WE), .D_A(D_A), .D_WD(D_WD), .D_RD(D_RD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Port model: the flag is loaded with 'hold' on a data write and counts down,
    // giving hold-1 WAIT cycles per byte; 'stuck' freezes it busy.
    always @(negedge CLK) begin
        if (D_WE && D_A == 4'd0) busy_cnt = hold;
        else if (busy_cnt != 0 && !stuck) busy_cnt = busy_cnt - 1;
    end
    assign D_RD = {31'd0, busy_cnt != 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge CLK) begin
        if (RESET_N) begin
            if (D_WE) begin
                if (D_A == 4'd0) begin
                    wr_cnt++;
                    wr_cyc = cyc;
                end else if (D_WD[0]) begin
                    sel_cyc = cyc;
                end else begin
                    desel_cnt++;
                    desel_cyc = cyc;
                end
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL dport_unexpected: got a=%0d wd=0x%0h, expected no write", D_A, D_WD);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (D_A === mon_e.a && D_WD === mon_e.wd) begin
                        n_pass++;
                        $display("dport cyc=%0d a=%0d wd=0x%02h ok", cyc, D_A, D_WD);
                    end else begin
                        $display("FAIL dport_write: got a=%0d wd=0x%0h, expected a=%0d wd=0x%0h",
                                 D_A, D_WD, mon_e.a, mon_e.wd);
                    end
                end
            end else if (D_A != 4'd0 || D_WD != 32'd0) begin
                idle_bad++;
            end
        end
    end

    task automatic push(input logic [3:0] a, input logic [31:0] wd);
        dwr_t e;
        e.a  = a;
        e.wd = wd;
        exp_q.push_back(e);
    endtask

    task automatic cpu_wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge CLK);
        WE = 1'b1;
        A  = a;
        WD = d;
        last_wr_cyc = cyc;
        @(negedge CLK);
        WE = 1'b0;
        A  = 4'd0;
        WD = 32'd0;
    endtask

    task automatic cpu_rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge CLK);
        A = a;
        #1;
        d = RD;
        A = 4'd0;
    endtask

    task automatic wait_desel(input int budget);
        int start;
        start = desel_cnt;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            #1;
            if (desel_cnt != start) return;
        end
        n_checks++;
        $display("FAIL wait_desel: got no deselect, expected one within %0d cycles", budget);
    endtask

    task automatic wait_wr(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            #1;
            if (wr_cnt >= target) return;
        end
        n_checks++;
        $display("FAIL wait_wr: got %0d data writes, expected %0d within %0d cycles", wr_cnt, target, budget);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int start;
        int w0;
        RESET_N = 1'b0;
        WE = 1'b0;
        A  = 4'd0;
        WD = 32'd0;
        repeat (3) @(negedge CLK);
        #1;
        check("reset_dwe", 32'(D_WE), 32'd0);
        check("reset_status", RD, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Buffer fill with pointer wrap.
        cpu_wr(4'd2, 32'd0);
        for (int i = 1; i <= NB; i++) begin
            cpu_wr(4'd3, 32'(i));
            if (i == 5) begin
                cpu_rd(4'd2, rd);
                check("ptr_after_5", rd, 32'd5);
            end
        end
        cpu_rd(4'd2, rd);
        check("ptr_wrap", rd, 32'd0);

        // Full frame, one WAIT cycle per byte.
        hold = 2;
        push(4'd1, 32'h01);
        for (int i = 1; i <= NB; i++) push(4'd0, 32'(i));
        push(4'd1, 32'h00);
        cpu_wr(4'd0, 32'h1);
        start = last_wr_cyc;
        wait_desel(200);
        check("frame_sel_latency", 32'(sel_cyc - start), 32'd1);
        check("frame_len_b1", 32'(desel_cyc - sel_cyc), 32'(1 + NB * 4));
        cpu_rd(4'd0, rd);
        check("status_in_fin", rd, 32'h1);
        cpu_rd(4'd0, rd);
        check("status_frame_done", rd, 32'h2);

        // Control word transfer.
        cpu_wr(4'd0, 32'h8);
        cpu_rd(4'd0, rd);
        check("status_cleared", rd, 32'h0);
        cpu_wr(4'd1, 32'h5);
        cpu_wr(4'd4, 32'h4F);
        push(4'd1, 32'h17);
        push(4'd0, 32'h4F);
        push(4'd1, 32'h16);
        cpu_wr(4'd0, 32'h2);
        start = last_wr_cyc;
        wait_desel(100);
        check("ctrl_first_wr_latency", 32'(wr_cyc - start), 32'd2);
        cpu_rd(4'd0, rd);
        cpu_rd(4'd0, rd);
        check("status_ctrl_done", rd, 32'h2);

        // 64-cycle busy per byte; both start bits set (frame wins), mid-frame START and CFG change.
        hold = 65;
        cpu_wr(4'd0, 32'h8);
        push(4'd1, 32'h15);
        for (int i = 1; i <= NB; i++) push(4'd0, 32'(i));
        push(4'd1, 32'h00);
        w0 = wr_cnt;
        cpu_wr(4'd0, 32'h3);
        start = last_wr_cyc;
        wait_wr(w0 + 5, 500);
        cpu_rd(4'd0, rd);
        check("status_busy_mid", rd, 32'h1);
        cpu_wr(4'd0, 32'h2);
        cpu_wr(4'd1, 32'h0);
        wait_desel(3000);
        check("busy_sel_latency", 32'(sel_cyc - start), 32'd1);
        check("frame_len_b64", 32'(desel_cyc - sel_cyc), 32'(1 + NB * 67));
        cpu_rd(4'd0, rd);
        check("status_busy_fin", rd, 32'h1);
        cpu_rd(4'd0, rd);
        check("status_busy_done", rd, 32'h2);

        // Abort in the third byte's WAIT.
        hold = 10;
        cpu_wr(4'd0, 32'h8);
        push(4'd1, 32'h01);
        push(4'd0, 32'h01);
        push(4'd0, 32'h02);
        push(4'd0, 32'h03);
        push(4'd1, 32'h00);
        w0 = wr_cnt;
        cpu_wr(4'd0, 32'h1);
        wait_wr(w0 + 3, 200);
        repeat (2) @(negedge CLK);
        cpu_wr(4'd0, 32'h4);
        start = last_wr_cyc;
        wait_desel(50);
        check("abort_desel_latency", 32'(desel_cyc - start), 32'd1);
        check("abort_wr_count", 32'(wr_cnt - w0), 32'd3);
        cpu_rd(4'd0, rd);
        cpu_rd(4'd0, rd);
        check("status_abort", rd, 32'h2);

        // Busy never clears: timeout.
        hold = 2;
        stuck = 1'b1;
        cpu_wr(4'd0, 32'h8);
        cpu_wr(4'd4, 32'h5A);
        push(4'd1, 32'h03);
        push(4'd0, 32'h5A);
        push(4'd1, 32'h02);
        cpu_wr(4'd0, 32'h2);
        wait_desel(TMO + 50);
        check("timeout_wait_cycles", 32'(desel_cyc - wr_cyc), 32'(TMO + 2));
        cpu_rd(4'd0, rd);
        check("status_timeout_fin", rd, 32'h5);
        cpu_rd(4'd0, rd);
        check("status_timeout", rd, 32'h6);
        stuck = 1'b0;
        cpu_wr(4'd0, 32'h8);
        cpu_rd(4'd0, rd);
        check("status_timeout_clr", rd, 32'h0);

        // Reset in the middle of a data write.
        cpu_wr(4'd2, 32'd7);
        cpu_wr(4'd1, 32'h3);
        hold = 65;
        push(4'd1, 32'h0D);
        push(4'd0, 32'h01);
        push(4'd0, 32'h02);
        w0 = wr_cnt;
        cpu_wr(4'd0, 32'h1);
        wait_wr(w0 + 2, 300);
        check("pre_reset_dwe", 32'(D_WE), 32'd1);
        RESET_N = 1'b0;
        #1;
        check("reset_drops_dwe", 32'(D_WE), 32'd0);
        check("reset_drops_dwd", D_WD, 32'd0);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        cpu_rd(4'd0, rd);
        check("status_after_reset", rd, 32'h0);
        cpu_rd(4'd2, rd);
        check("ptr_after_reset", rd, 32'h0);

        // Recovery frame uses reset CFG and CWORD.
        hold = 2;
        push(4'd1, 32'h03);
        push(4'd0, 32'h00);
        push(4'd1, 32'h02);
        cpu_wr(4'd0, 32'h2);
        wait_desel(100);
        cpu_rd(4'd0, rd);
        cpu_rd(4'd0, rd);
        check("status_recovered", rd, 32'h2);

        repeat (3) @(negedge CLK);
        check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        check("idle_outputs_zero", 32'(idle_bad), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
